// File: rtl/vstu_w_buffer.sv
// W-channel decoupling buffer between the vector store unit and the AXI master port.
// Buffers W beats, caps bursts awaiting B, forwards B and flags error responses.
module vstu_w_buffer #(
    parameter  int unsigned AxiDataWidth   = 64,
    parameter  int unsigned Depth          = 4,
    parameter  int unsigned MaxOutstanding = 8,
    localparam int unsigned StrbWidth      = AxiDataWidth / 8,
    localparam int unsigned OutW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [AxiDataWidth-1:0] w_data_i,
    input  logic [StrbWidth-1:0]    w_strb_i,
    input  logic                    w_last_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    output logic [AxiDataWidth-1:0] axi_w_data_o,
    output logic [StrbWidth-1:0]    axi_w_strb_o,
    output logic                    axi_w_last_o,
    output logic                    axi_w_valid_o,
    input  logic                    axi_w_ready_i,
    input  logic [1:0]              axi_b_resp_i,
    input  logic                    axi_b_valid_i,
    output logic                    axi_b_ready_o,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [OutW-1:0]         outstanding_o,
    output logic                    err_o,
    output logic                    idle_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(Depth);
    localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [OutW-1:0] OutMax  = OutW'(MaxOutstanding);
    localparam logic [OutW-1:0] OutOne  = OutW'(1);

    logic [AxiDataWidth-1:0] mem_data_q [Depth];
    logic [StrbWidth-1:0]    mem_strb_q [Depth];
    logic                    mem_last_q [Depth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [OutW-1:0] out_q, out_d;
    logic            err_q, err_d;

    logic empty, full, push, pop, b_hs, out_inc;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCnt);

    assign w_ready_o = !full && (out_q < OutMax);
    assign push      = w_valid_i && w_ready_o;

    assign axi_w_valid_o = !empty;
    assign axi_w_data_o  = empty ? '0 : mem_data_q[rd_ptr_q];
    assign axi_w_strb_o  = empty ? '0 : mem_strb_q[rd_ptr_q];
    assign axi_w_last_o  = empty ? 1'b0 : mem_last_q[rd_ptr_q];
    assign pop           = axi_w_valid_o && axi_w_ready_i;

    assign b_valid_o     = axi_b_valid_i;
    assign axi_b_ready_o = b_ready_i;
    assign b_hs          = axi_b_valid_i && b_ready_i;
    assign out_inc       = push && w_last_i;

    assign outstanding_o = out_q;
    assign err_o         = err_q;
    assign idle_o        = empty && (out_q == '0);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (pop && !push) begin
            count_d = count_q - CntOne;
        end
        // A stray B with nothing outstanding is forwarded but must not underflow.
        out_d = out_q;
        if (out_inc && !b_hs) begin
            out_d = out_q + OutOne;
        end else if (b_hs && !out_inc && (out_q != '0)) begin
            out_d = out_q - OutOne;
        end
        err_d = err_q || (b_hs && (axi_b_resp_i != 2'b00));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= w_data_i;
            mem_strb_q[wr_ptr_q] <= w_strb_i;
            mem_last_q[wr_ptr_q] <= w_last_i;
        end
    end
endmodule

// File: tb/tb_vstu_w_buffer.sv
// Directed bench for vstu_w_buffer: accepted W beats go into a scoreboard queue,
// a monitor pops and compares every AXI W handshake.
module tb_vstu_w_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] w_data_i;
    logic [7:0]  w_strb_i;
    logic        w_last_i;
    logic        w_valid_i;
    logic        w_ready_o;
    logic [63:0] axi_w_data_o;
    logic [7:0]  axi_w_strb_o;
    logic        axi_w_last_o;
    logic        axi_w_valid_o;
    logic        axi_w_ready_i;
    logic [1:0]  axi_b_resp_i;
    logic        axi_b_valid_i;
    logic        axi_b_ready_o;
    logic        b_valid_o;
    logic        b_ready_i;
    logic [3:0]  outstanding_o;
    logic        err_o;
    logic        idle_o;

    int tests = 0;
    int fails = 0;
    logic [72:0] sb[$];

    vstu_w_buffer #(.AxiDataWidth(64), .Depth(4), .MaxOutstanding(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o),
        .axi_w_last_o(axi_w_last_o), .axi_w_valid_o(axi_w_valid_o),
        .axi_w_ready_i(axi_w_ready_i), .axi_b_resp_i(axi_b_resp_i),
        .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .outstanding_o(outstanding_o), .err_o(err_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a beat and hold it until accepted; returns just after the accepting edge.
    task automatic push_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
        bit done = 0;
        w_data_i  = d;
        w_strb_i  = s;
        w_last_i  = l;
        w_valid_i = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_i);
            if (w_ready_o) begin
                sb.push_back({d, s, l});
                done = 1;
            end
            cyc();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: beat 0x%0h not accepted within 20 cycles", d);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && axi_w_valid_o && axi_w_ready_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL w_unexpected: beat 0x%0h emitted with empty scoreboard", axi_w_data_o);
            end else begin
                logic [72:0] e;
                e = sb.pop_front();
                tests++;
                if ({axi_w_data_o, axi_w_strb_o, axi_w_last_o} !== e) begin
                    fails++;
                    $display("FAIL w_beat: got %h/%h/%b expected %h/%h/%b",
                             axi_w_data_o, axi_w_strb_o, axi_w_last_o, e[72:9], e[8:1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0; w_valid_i = 1'b0;
        axi_w_ready_i = 1'b0; axi_b_resp_i = 2'b00; axi_b_valid_i = 1'b0; b_ready_i = 1'b0;

        // Reset values
        @(negedge clk_i);
        check("rst_w_ready", w_ready_o, 1);
        check("rst_axi_valid", axi_w_valid_o, 0);
        check("rst_axi_data", axi_w_data_o, 0);
        check("rst_idle", idle_o, 1);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_err", err_o, 0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Single-beat burst, then B OKAY
        axi_w_ready_i = 1'b1;
        w_data_i = 64'hDEADBEEF_00000001; w_strb_i = 8'hFF; w_last_i = 1'b1; w_valid_i = 1'b1;
        @(negedge clk_i);
        check("single_ready", w_ready_o, 1);
        check("no_fallthrough", axi_w_valid_o, 0);
        if (w_ready_o) sb.push_back({64'hDEADBEEF_00000001, 8'hFF, 1'b1});
        cyc();
        w_valid_i = 1'b0;
        @(negedge clk_i);
        check("single_axi_valid", axi_w_valid_o, 1);
        check("single_outstanding", outstanding_o, 1);
        check("single_not_idle", idle_o, 0);
        cyc(); cyc(); cyc();
        axi_b_valid_i = 1'b1; b_ready_i = 1'b1; axi_b_resp_i = 2'b00;
        @(negedge clk_i);
        check("b_fwd_valid", b_valid_o, 1);
        check("b_fwd_ready", axi_b_ready_o, 1);
        cyc();
        axi_b_valid_i = 1'b0;
        @(negedge clk_i);
        check("single_out_zero", outstanding_o, 0);
        check("single_idle", idle_o, 1);
        cyc();

        // Fill the FIFO with AXI stalled, then stream through
        axi_w_ready_i = 1'b0;
        push_beat(64'h1111_0000_0000_00A0, 8'h01, 1'b0);
        push_beat(64'h1111_0000_0000_00A1, 8'h03, 1'b0);
        push_beat(64'h1111_0000_0000_00A2, 8'h0F, 1'b0);
        push_beat(64'h1111_0000_0000_00A3, 8'hF0, 1'b0);
        w_data_i = 64'h1111_0000_0000_00A4; w_strb_i = 8'hAA; w_last_i = 1'b0; w_valid_i = 1'b1;
        @(negedge clk_i);
        check("full_w_ready", w_ready_o, 0);
        check("full_axi_valid", axi_w_valid_o, 1);
        cyc();
        axi_w_ready_i = 1'b1;
        push_beat(64'h1111_0000_0000_00A4, 8'hAA, 1'b0);
        push_beat(64'h1111_0000_0000_00A5, 8'h55, 1'b0);
        push_beat(64'h1111_0000_0000_00A6, 8'h3C, 1'b0);
        push_beat(64'h1111_0000_0000_00A7, 8'hC3, 1'b1);
        w_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        @(negedge clk_i);
        check("stream_drained", axi_w_valid_o, 0);
        check("stream_sb_empty", sb.size(), 0);
        check("stream_outstanding", outstanding_o, 1);
        cyc();
        axi_b_valid_i = 1'b1; b_ready_i = 1'b1;
        cyc();
        axi_b_valid_i = 1'b0;

        // Outstanding cap
        for (int i = 0; i < 8; i++) push_beat(64'h2222_0000_0000_0000 | 64'(i), 8'hFF, 1'b1);
        w_data_i = 64'h2222_FFFF_0000_0000; w_last_i = 1'b0; w_valid_i = 1'b1;
        @(negedge clk_i);
        check("cap_outstanding", outstanding_o, 8);
        check("cap_w_ready", w_ready_o, 0);
        cyc();
        w_valid_i = 1'b0; axi_b_valid_i = 1'b1; b_ready_i = 1'b1; axi_b_resp_i = 2'b00;
        @(negedge clk_i);
        check("cap_still_8", outstanding_o, 8);
        cyc();
        axi_b_valid_i = 1'b0;
        @(negedge clk_i);
        check("cap_after_b", outstanding_o, 7);
        check("cap_ready_again", w_ready_o, 1);
        cyc();
        axi_b_valid_i = 1'b1;
        push_beat(64'h3333_0000_0000_0001, 8'h0F, 1'b1);
        axi_b_valid_i = 1'b0; w_valid_i = 1'b0;
        @(negedge clk_i);
        check("simul_inc_dec", outstanding_o, 7);
        cyc();

        // Error response and stray B
        axi_b_valid_i = 1'b1; axi_b_resp_i = 2'b10;
        @(negedge clk_i);
        check("err_not_yet", err_o, 0);
        cyc();
        axi_b_resp_i = 2'b00;
        @(negedge clk_i);
        check("err_set", err_o, 1);
        check("err_outstanding", outstanding_o, 6);
        cyc();
        axi_b_valid_i = 1'b0;
        @(negedge clk_i);
        check("err_sticky", err_o, 1);
        check("err_out5", outstanding_o, 5);
        cyc();
        axi_b_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        axi_b_valid_i = 1'b0;
        @(negedge clk_i);
        check("drain_out0", outstanding_o, 0);
        check("drain_idle", idle_o, 1);
        check("drain_err_sticky", err_o, 1);
        cyc();
        axi_b_valid_i = 1'b1;
        @(negedge clk_i);
        check("stray_b_fwd", b_valid_o, 1);
        cyc();
        axi_b_valid_i = 1'b0;
        @(negedge clk_i);
        check("stray_no_underflow", outstanding_o, 0);
        cyc();
        b_ready_i = 1'b0; axi_b_valid_i = 1'b1;
        @(negedge clk_i);
        check("b_ready_pass_low", axi_b_ready_o, 0);
        cyc();
        axi_b_valid_i = 1'b0;

        // Reset mid-burst with three beats buffered
        axi_w_ready_i = 1'b0;
        push_beat(64'h4444_0000_0000_0001, 8'hFF, 1'b0);
        push_beat(64'h4444_0000_0000_0002, 8'hFF, 1'b0);
        push_beat(64'h4444_0000_0000_0003, 8'hFF, 1'b1);
        w_valid_i = 1'b0;
        @(negedge clk_i);
        check("pre_rst_out", outstanding_o, 1);
        check("pre_rst_valid", axi_w_valid_o, 1);
        cyc();
        rst_ni = 1'b0;
        #1;
        check("arst_valid", axi_w_valid_o, 0);
        check("arst_data", axi_w_data_o, 0);
        check("arst_w_ready", w_ready_o, 1);
        check("arst_idle", idle_o, 1);
        check("arst_out", outstanding_o, 0);
        check("arst_err", err_o, 0);
        sb.delete();
        cyc();
        rst_ni = 1'b1; axi_w_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("post_rst_no_w", axi_w_valid_o, 0);
            cyc();
        end
        check("end_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vstu_w_buffer.md
Name: vstu_w_buffer

Overview:
Decoupling stage directly downstream of the vector store unit, between its W/B interface and the AXI master port. It buffers W beats in a small FIFO so lane-operand stalls do not create W-channel bubbles. It tracks bursts whose last W beat has been accepted but whose B response has not yet returned, and caps that number. It forwards B responses upstream, flags error responses, and reports idle to the dispatcher.

Parameters:
AxiDataWidth, 64, W data width in bits; strobe width is AxiDataWidth/8.
Depth, 4, W FIFO entries; power of two, at least 2.
MaxOutstanding, 8, maximum bursts awaiting a B response; at least 1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
w_data_i  in  AxiDataWidth  W data from store unit
w_strb_i  in  AxiDataWidth/8  W strobes from store unit
w_last_i  in  1  last beat of burst
w_valid_i  in  1  upstream W valid
w_ready_o  out  1  upstream W ready
axi_w_data_o  out  AxiDataWidth  W data to AXI
axi_w_strb_o  out  AxiDataWidth/8  W strobes to AXI
axi_w_last_o  out  1  W last to AXI
axi_w_valid_o  out  1  AXI W valid
axi_w_ready_i  in  1  AXI W ready
axi_b_resp_i  in  2  AXI B response code
axi_b_valid_i  in  1  AXI B valid
axi_b_ready_o  out  1  AXI B ready
b_valid_o  out  1  B response forwarded to store unit
b_ready_i  in  1  store-unit B ready
outstanding_o  out  $clog2(MaxOutstanding+1)  bursts awaiting B
err_o  out  1  sticky: a B response other than OKAY was seen
idle_o  out  1  FIFO empty and outstanding_o == 0

Behaviour:
- Reset (async, rst_ni low): FIFO empty, pointers 0, outstanding 0, err_o 0. Resulting outputs: axi_w_valid_o 0, axi_w_* data/strb/last 0, w_ready_o 1, idle_o 1. Reset mid-burst drops all buffered beats; no W is emitted afterwards until a new push.
- FIFO storage: {data, strb, last}; read and write pointers of log2(Depth) bits that wrap naturally; count of log2(Depth)+1 bits.
- Push condition: w_valid_i && w_ready_o.
- w_ready_o = !full && (outstanding < MaxOutstanding). This is combinational from registered state only and never depends on w_valid_i.
- Pop condition: axi_w_valid_o && axi_w_ready_i. axi_w_valid_o = !empty. axi_w_* are driven from the head entry, and are 0 when empty.
- No fall-through: a beat pushed in cycle N is visible on AXI at N+1 at the earliest, so minimum latency is 1 cycle.
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged.
  - When full, push is refused because w_ready_o is 0, even if a pop occurs that cycle.
- Outstanding counter:
  - +1 on a push with w_last_i = 1.
  - -1 on an AXI B handshake.
  - Both in the same cycle: no change.
  - The counter is incremented when the last beat enters the FIFO, not when it leaves.
  - At MaxOutstanding, w_ready_o = 0 for every beat, including non-last beats, until a B arrives.
  - A B handshake while outstanding == 0 is a protocol violation: the counter stays at 0 (no underflow), and the response is still forwarded.
- B path (combinational passthrough, no buffering):
  - b_valid_o = axi_b_valid_i.
  - axi_b_ready_o = b_ready_i.
  - B handshake = axi_b_valid_i && b_ready_i.
- err_o: set on a B handshake with axi_b_resp_i != 2'b00. Cleared only by reset.
- idle_o: registered-state function (empty && outstanding == 0). It drops in the cycle after the first push.

Test Plan:
- Reset, then idle -> w_ready_o=1, axi_w_valid_o=0, idle_o=1, outstanding_o=0, err_o=0.
- Single-beat burst pushed at cycle 0 with data 0xDEADBEEF_00000001, strb 0xFF, last=1; axi_w_ready_i=1 -> beat appears on AXI at cycle 1, outstanding_o=1 from cycle 1. B OKAY handshake at cycle 5 -> outstanding_o=0, idle_o=1 at cycle 6.
- axi_w_ready_i held 0; push 4 non-last beats (Depth=4) -> w_ready_o=0 after the 4th. Then raise axi_w_ready_i with w_valid_i high -> 4 beats drain in order, and the accepted stream continues with one push and one pop per cycle.
- 8 single-beat bursts with no B (MaxOutstanding=8) -> w_ready_o=0 with outstanding_o=8. One B handshake in the same cycle as no push -> outstanding_o=7, w_ready_o=1 next cycle. A last-beat push simultaneous with a B handshake -> outstanding_o unchanged.
- B with resp 2'b10 -> err_o=1 from the next cycle and stays 1 after further OKAY responses. B with outstanding_o=0 -> b_valid_o=1 is forwarded and outstanding_o stays 0.
- Reset asserted mid-burst with 3 beats buffered -> outputs return to reset values immediately, buffered beats are never emitted, and outstanding_o=0.
